// File: rtl/arbitro_compuerta.sv
// Barrier gate arbiter: shares one gate motor between the entry and exit lane
// controllers, sequencing each grant through open, hold, pass and close strokes.
module arbitro_compuerta #(
    parameter int TIEMPO_MOTOR  = 4,
    parameter int TIEMPO_ESPERA = 10,
    parameter int CNT_W         = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic sol_entrada,
    input  logic sol_salida,
    input  logic sensor_paso,
    input  logic bloqueo,
    output logic conc_entrada,
    output logic conc_salida,
    output logic motor_abrir,
    output logic motor_cerrar,
    output logic compuerta_abierta,
    output logic alarma_tiempo,
    output logic ocupado
);

    typedef enum logic [2:0] {
        REPOSO   = 3'd0,
        ABRIENDO = 3'd1,
        ABIERTA  = 3'd2,
        PASANDO  = 3'd3,
        CERRANDO = 3'd4
    } estado_t;

    localparam logic [CNT_W-1:0] FIN_MOTOR  = CNT_W'(TIEMPO_MOTOR - 1);
    localparam logic [CNT_W-1:0] FIN_ESPERA = CNT_W'(TIEMPO_ESPERA - 1);
    localparam logic [CNT_W-1:0] UNO        = CNT_W'(1);

    estado_t          estado_r, estado_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             conc_ent_r, conc_ent_s;
    logic             conc_sal_r, conc_sal_s;
    logic             prio_r, prio_s;      // 0 = entry wins a tie, 1 = exit wins
    logic             alarma_s;
    logic             motor_abrir_r, motor_cerrar_r, abierta_r, alarma_r, ocupado_r;

    // States in which the stroke/wait counter advances every cycle.
    function automatic logic estado_cuenta(input estado_t e);
        logic r;
        case (e)
            ABRIENDO: r = 1'b1;
            ABIERTA:  r = 1'b1;
            CERRANDO: r = 1'b1;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

    // Next-state, grant and priority decision from the registered state.
    always_comb begin
        estado_s   = estado_r;
        conc_ent_s = conc_ent_r;
        conc_sal_s = conc_sal_r;
        prio_s     = prio_r;
        alarma_s   = 1'b0;
        case (estado_r)
            REPOSO: begin
                if (!bloqueo && (sol_entrada || sol_salida)) begin
                    estado_s = ABRIENDO;
                    if (sol_entrada && sol_salida) begin
                        conc_ent_s = ~prio_r;
                        conc_sal_s = prio_r;
                    end else begin
                        conc_ent_s = sol_entrada;
                        conc_sal_s = sol_salida;
                    end
                end else begin
                    conc_ent_s = 1'b0;
                    conc_sal_s = 1'b0;
                end
            end
            ABRIENDO: begin
                if (bloqueo && !sensor_paso) begin
                    estado_s = CERRANDO;
                end else if (cnt_r == FIN_MOTOR) begin
                    estado_s = ABIERTA;
                end else begin
                    estado_s = ABRIENDO;
                end
            end
            ABIERTA: begin
                if (sensor_paso) begin
                    estado_s = PASANDO;
                end else if (cnt_r == FIN_ESPERA) begin
                    estado_s = CERRANDO;
                    alarma_s = 1'b1;
                end else if (bloqueo) begin
                    estado_s = CERRANDO;
                end else begin
                    estado_s = ABIERTA;
                end
            end
            PASANDO: begin
                // A vehicle under the barrier always wins over the lock.
                if (!sensor_paso) begin
                    estado_s = CERRANDO;
                end else begin
                    estado_s = PASANDO;
                end
            end
            CERRANDO: begin
                if (sensor_paso) begin
                    estado_s = ABRIENDO;
                end else if (cnt_r == FIN_MOTOR) begin
                    estado_s   = REPOSO;
                    conc_ent_s = 1'b0;
                    conc_sal_s = 1'b0;
                    prio_s     = conc_ent_r;
                end else begin
                    estado_s = CERRANDO;
                end
            end
            default: begin
                estado_s   = REPOSO;
                conc_ent_s = 1'b0;
                conc_sal_s = 1'b0;
            end
        endcase
    end

    // Counter restarts on every state change and runs only in timed states.
    always_comb begin
        cnt_s = cnt_r;
        if (estado_s != estado_r) begin
            cnt_s = '0;
        end else if (estado_cuenta(estado_r)) begin
            cnt_s = cnt_r + UNO;
        end else begin
            cnt_s = cnt_r;
        end
    end

    // State, grant and Moore output registers, decoded from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_r       <= REPOSO;
            cnt_r          <= '0;
            conc_ent_r     <= 1'b0;
            conc_sal_r     <= 1'b0;
            prio_r         <= 1'b0;
            motor_abrir_r  <= 1'b0;
            motor_cerrar_r <= 1'b0;
            abierta_r      <= 1'b0;
            alarma_r       <= 1'b0;
            ocupado_r      <= 1'b0;
        end else begin
            estado_r       <= estado_s;
            cnt_r          <= cnt_s;
            conc_ent_r     <= conc_ent_s;
            conc_sal_r     <= conc_sal_s;
            prio_r         <= prio_s;
            motor_abrir_r  <= (estado_s == ABRIENDO);
            motor_cerrar_r <= (estado_s == CERRANDO);
            abierta_r      <= (estado_s == ABIERTA) || (estado_s == PASANDO);
            alarma_r       <= alarma_s;
            ocupado_r      <= (estado_s != REPOSO);
        end
    end

    assign conc_entrada      = conc_ent_r;
    assign conc_salida       = conc_sal_r;
    assign motor_abrir       = motor_abrir_r;
    assign motor_cerrar      = motor_cerrar_r;
    assign compuerta_abierta = abierta_r;
    assign alarma_tiempo     = alarma_r;
    assign ocupado           = ocupado_r;

endmodule

// File: tb/tb_arbitro_compuerta.sv
// Bench for arbitro_compuerta: directed scenarios plus random traffic, each
// cycle compared against a countdown-based phase model of the gate.
module tb_arbitro_compuerta;

    localparam int TM = 4;
    localparam int TE = 10;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic sol_entrada = 1'b0, sol_salida = 1'b0, sensor_paso = 1'b0, bloqueo = 1'b0;
    logic conc_entrada, conc_salida, motor_abrir, motor_cerrar;
    logic compuerta_abierta, alarma_tiempo, ocupado;
    logic [6:0] obs;

    int total = 0;
    int pasadas = 0;

    arbitro_compuerta #(.TIEMPO_MOTOR(TM), .TIEMPO_ESPERA(TE), .CNT_W(8)) dut (
        .clock(clock), .reset(reset),
        .sol_entrada(sol_entrada), .sol_salida(sol_salida),
        .sensor_paso(sensor_paso), .bloqueo(bloqueo),
        .conc_entrada(conc_entrada), .conc_salida(conc_salida),
        .motor_abrir(motor_abrir), .motor_cerrar(motor_cerrar),
        .compuerta_abierta(compuerta_abierta), .alarma_tiempo(alarma_tiempo),
        .ocupado(ocupado)
    );

    assign obs = {conc_entrada, conc_salida, motor_abrir, motor_cerrar,
                  compuerta_abierta, alarma_tiempo, ocupado};

    always #5 clock = ~clock;

    // Reference model: phase plus cycles remaining in it; owner 1 = entry, 2 = exit.
    localparam int F_IDLE = 0, F_SUBE = 1, F_ARRIBA = 2, F_VEH = 3, F_BAJA = 4;
    int   m_fase, m_dueno, m_turno, m_quedan;
    logic m_alarma;

    task automatic modelo_reset();
        m_fase = F_IDLE; m_dueno = 0; m_turno = 1; m_quedan = 0; m_alarma = 1'b0;
    endtask

    task automatic paso_modelo();
        m_alarma = 1'b0;
        case (m_fase)
            F_IDLE: if (!bloqueo && (sol_entrada || sol_salida)) begin
                m_dueno  = (sol_entrada && sol_salida) ? m_turno : (sol_entrada ? 1 : 2);
                m_fase   = F_SUBE;
                m_quedan = TM;
            end
            F_SUBE: if (bloqueo && !sensor_paso) begin
                m_fase = F_BAJA; m_quedan = TM;
            end else begin
                m_quedan--;
                if (m_quedan == 0) begin m_fase = F_ARRIBA; m_quedan = TE; end
            end
            F_ARRIBA: if (sensor_paso) begin
                m_fase = F_VEH;
            end else begin
                m_quedan--;
                if (m_quedan == 0) begin
                    m_fase = F_BAJA; m_quedan = TM; m_alarma = 1'b1;
                end else if (bloqueo) begin
                    m_fase = F_BAJA; m_quedan = TM;
                end
            end
            F_VEH: if (!sensor_paso) begin m_fase = F_BAJA; m_quedan = TM; end
            F_BAJA: if (sensor_paso) begin
                m_fase = F_SUBE; m_quedan = TM;
            end else begin
                m_quedan--;
                if (m_quedan == 0) begin
                    m_fase  = F_IDLE;
                    m_turno = (m_dueno == 1) ? 2 : 1;
                    m_dueno = 0;
                end
            end
            default: m_fase = F_IDLE;
        endcase
    endtask

    function automatic logic [6:0] esperado();
        return {m_dueno == 1, m_dueno == 2, m_fase == F_SUBE, m_fase == F_BAJA,
                (m_fase == F_ARRIBA) || (m_fase == F_VEH), m_alarma, m_fase != F_IDLE};
    endfunction

    task automatic avanzar();
        @(posedge clock);
        paso_modelo();
        #1;
    endtask

    task automatic reiniciar();
        reset = 1'b0;
        sol_entrada = 1'b0; sol_salida = 1'b0; sensor_paso = 1'b0; bloqueo = 1'b0;
        modelo_reset();
        #3;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        modelo_reset();
        #2;
        total++;
        if (obs !== 7'b0) $display("FAIL reset_inicial: salidas %b, esperadas %b", obs, 7'b0);
        else pasadas++;
        @(posedge clock);
        #1;
        total++;
        if (obs !== 7'b0) $display("FAIL reset_flanco: salidas %b, esperadas %b", obs, 7'b0);
        else pasadas++;
        #3;
        reset = 1'b1;
    endtask

    task automatic test_secuencia_basica();
        reiniciar();
        for (int k = 1; k <= 20; k++) begin
            sol_entrada = (k == 1);
            sensor_paso = (k >= 7 && k <= 9);
            avanzar();
            total++;
            if (obs !== esperado()) $display("FAIL basica ciclo %0d: salidas %b, esperadas %b", k, obs, esperado());
            else pasadas++;
            if (k == 1) begin
                total++;
                if ({conc_entrada, motor_abrir} !== 2'b11)
                    $display("FAIL basica_latencia: conc/abrir %b, esperado %b", {conc_entrada, motor_abrir}, 2'b11);
                else pasadas++;
            end
        end
        total++;
        if (ocupado !== 1'b0) $display("FAIL basica_fin: ocupado %b, esperado 0", ocupado);
        else pasadas++;
    endtask

    task automatic test_alternancia();
        logic [1:0] vistos [3];
        int n = 0;
        int inactivos = 0;
        logic ocu_prev = 1'b0;
        reiniciar();
        sol_entrada = 1'b1; sol_salida = 1'b1;
        for (int k = 0; k < 80 && n < 3; k++) begin
            avanzar();
            total++;
            if (obs !== esperado()) $display("FAIL alterna ciclo %0d: salidas %b, esperadas %b", k, obs, esperado());
            else pasadas++;
            total++;
            if (conc_entrada && conc_salida) $display("FAIL alterna_solape: conc %b, esperado no ambos", {conc_entrada, conc_salida});
            else pasadas++;
            if (!ocu_prev && ocupado) begin
                if (n > 0) begin
                    total++;
                    if (inactivos != 1) $display("FAIL alterna_hueco: ciclos libres %0d, esperado 1", inactivos);
                    else pasadas++;
                end
                vistos[n] = {conc_entrada, conc_salida};
                n++;
                inactivos = 0;
            end else if (!ocupado) begin
                inactivos++;
            end
            ocu_prev = ocupado;
        end
        total++;
        if (n != 3) $display("FAIL alterna_limite: servicios %0d, esperados 3", n);
        else if ({vistos[0], vistos[1], vistos[2]} !== 6'b10_01_10)
            $display("FAIL alterna_orden: concesiones %b, esperadas %b", {vistos[0], vistos[1], vistos[2]}, 6'b100110);
        else pasadas++;
        sol_entrada = 1'b0; sol_salida = 1'b0;
        for (int k = 0; k < 25; k++) begin
            avanzar();
            total++;
            if (obs !== esperado()) $display("FAIL alterna_vaciado %0d: salidas %b, esperadas %b", k, obs, esperado());
            else pasadas++;
        end
    endtask

    task automatic test_timeout();
        int n_abierta = 0;
        int n_alarma = 0;
        logic prev_abierta = 1'b0;
        reiniciar();
        sol_salida = 1'b1;
        avanzar();
        sol_salida = 1'b0;
        for (int k = 0; k < 25; k++) begin
            total++;
            if (obs !== esperado()) $display("FAIL timeout ciclo %0d: salidas %b, esperadas %b", k, obs, esperado());
            else pasadas++;
            if (compuerta_abierta) n_abierta++;
            if (alarma_tiempo) begin
                n_alarma++;
                total++;
                if ({motor_cerrar, prev_abierta} !== 2'b11)
                    $display("FAIL timeout_alarma: cerrar/abierta_prev %b, esperado %b", {motor_cerrar, prev_abierta}, 2'b11);
                else pasadas++;
            end
            prev_abierta = compuerta_abierta;
            avanzar();
        end
        total++;
        if (n_abierta != TE || n_alarma != 1)
            $display("FAIL timeout_cuentas: abierta %0d alarma %0d, esperado %0d y 1", n_abierta, n_alarma, TE);
        else pasadas++;
    endtask

    task automatic test_reapertura();
        int n_abrir = 0;
        reiniciar();
        sol_entrada = 1'b1;
        avanzar();
        sol_entrada = 1'b0;
        for (int k = 0; k < 30 && m_fase != F_BAJA; k++) avanzar();
        avanzar();
        total++;
        if (m_fase != F_BAJA || obs !== esperado())
            $display("FAIL reapertura_cierre: salidas %b, esperadas %b", obs, esperado());
        else pasadas++;
        sensor_paso = 1'b1;
        avanzar();
        sensor_paso = 1'b0;
        total++;
        if ({motor_abrir, motor_cerrar, conc_entrada, conc_salida} !== 4'b1010)
            $display("FAIL reapertura_giro: abrir/cerrar/conc %b, esperado %b",
                     {motor_abrir, motor_cerrar, conc_entrada, conc_salida}, 4'b1010);
        else pasadas++;
        for (int k = 0; k < 30; k++) begin
            if (motor_abrir) n_abrir++;
            total++;
            if (obs !== esperado()) $display("FAIL reapertura ciclo %0d: salidas %b, esperadas %b", k, obs, esperado());
            else pasadas++;
            avanzar();
        end
        total++;
        if (n_abrir != TM) $display("FAIL reapertura_carrera: ciclos abrir %0d, esperados %0d", n_abrir, TM);
        else pasadas++;
    endtask

    task automatic test_bloqueo();
        reiniciar();
        bloqueo = 1'b1; sol_entrada = 1'b1; sol_salida = 1'b1;
        for (int k = 0; k < 20; k++) begin
            avanzar();
            total++;
            if (ocupado !== 1'b0 || obs !== esperado())
                $display("FAIL bloqueo_reposo ciclo %0d: salidas %b, esperadas %b", k, obs, 7'b0);
            else pasadas++;
        end
        bloqueo = 1'b0; sol_salida = 1'b0;
        avanzar();
        sol_entrada = 1'b0;
        for (int k = 0; k < 10 && m_fase != F_ARRIBA; k++) avanzar();
        sensor_paso = 1'b1;
        avanzar();
        bloqueo = 1'b1;
        for (int k = 0; k < 5; k++) begin
            avanzar();
            total++;
            if (compuerta_abierta !== 1'b1 || obs !== esperado())
                $display("FAIL bloqueo_paso ciclo %0d: salidas %b, esperadas %b", k, obs, esperado());
            else pasadas++;
        end
        sensor_paso = 1'b0;
        for (int k = 0; k < 8; k++) begin
            avanzar();
            total++;
            if (obs !== esperado()) $display("FAIL bloqueo_cierre ciclo %0d: salidas %b, esperadas %b", k, obs, esperado());
            else pasadas++;
        end
        total++;
        if (ocupado !== 1'b0) $display("FAIL bloqueo_fin: ocupado %b, esperado 0", ocupado);
        else pasadas++;
        bloqueo = 1'b0;
    endtask

    task automatic test_aleatorio();
        reiniciar();
        for (int k = 0; k < 1500; k++) begin
            sol_entrada = ($urandom_range(0, 2) == 0);
            sol_salida  = ($urandom_range(0, 2) == 0);
            bloqueo     = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) sensor_paso = ~sensor_paso;
            avanzar();
            total++;
            if (obs !== esperado() || (conc_entrada && conc_salida) || (motor_abrir && motor_cerrar))
                $display("FAIL aleatorio ciclo %0d: salidas %b, esperadas %b", k, obs, esperado());
            else pasadas++;
        end
    endtask

    task automatic test_reset_async();
        reiniciar();
        sol_entrada = 1'b1;
        avanzar();
        sol_entrada = 1'b0;
        for (int k = 0; k < 40 && m_fase != F_IDLE; k++) avanzar();
        sol_entrada = 1'b1;
        avanzar();
        sol_entrada = 1'b0;
        avanzar();
        total++;
        if (motor_abrir !== 1'b1 || obs !== esperado())
            $display("FAIL async_previo: salidas %b, esperadas %b", obs, esperado());
        else pasadas++;
        #2;
        reset = 1'b0;
        modelo_reset();
        #1;
        total++;
        if (obs !== 7'b0) $display("FAIL async_inmediato: salidas %b, esperadas %b", obs, 7'b0);
        else pasadas++;
        #2;
        reset = 1'b1;
        sol_entrada = 1'b1; sol_salida = 1'b1;
        avanzar();
        total++;
        if ({conc_entrada, conc_salida} !== 2'b10 || obs !== esperado())
            $display("FAIL async_prioridad: salidas %b, esperadas %b", obs, esperado());
        else pasadas++;
        sol_entrada = 1'b0; sol_salida = 1'b0;
    endtask

    initial begin
        test_reset();
        test_secuencia_basica();
        test_alternancia();
        test_timeout();
        test_reapertura();
        test_bloqueo();
        test_aleatorio();
        test_reset_async();
        $display("%0d/%0d checks passed", pasadas, total);
        $finish;
    end

endmodule
